armv4_mem_arbiter: RTL and testbench
====================================

// Module: armv4_mem_arbiter
// PURPOSE
//  Sits directly below armv4core: merges its fixed-latency rom bus (fetch) and ram bus (load/store)
//  onto one shared memory port with req/gnt/rvalid handshake, so core and a single slow memory can coexist.
//  Stalls the core through its en input while accesses are outstanding; does byte-lane steering for B/H/W.
// PARAMETERS
//  ADDR_W   32  address width (core and memory side)
//  RAM_PRIO 1   1: data access issued before fetch when both requested in the same cycle; 0: fetch first
// PORTS
//  clk           in  1   clock, all state on rising edge
//  rst           in  1   reset, asynchronous, active-high
//  o_core_en     out 1   to armv4core en; 0 = core stalled
//  i_rom_en      in  1   core fetch request
//  i_rom_addr    in  32  fetch byte address (word aligned)
//  o_rom_data    out 32  fetched instruction, held until next fetch completes
//  i_ram_en      in  1   core data request
//  i_ram_wr      in  1   1 = store, 0 = load
//  i_ram_size    in  2   `MEM_B / `MEM_H / other = word (def.v encodings)
//  i_ram_addr    in  32  data byte address
//  i_ram_wdata   in  32  store data, right-aligned
//  o_ram_rdata   out 32  load data, zero-extended, held until next load completes
//  o_mem_req     out 1   memory request
//  o_mem_wr      out 1   memory write
//  o_mem_be      out 4   byte enables (bit n = byte lane n)
//  o_mem_addr    out 32  word address {addr[31:2],2'b00}
//  o_mem_wdata   out 32  lane-replicated write data
//  i_mem_gnt     in  1   request accepted this cycle
//  i_mem_rvalid  in  1   read data valid (earliest cycle after gnt)
//  i_mem_rdata   in  32  read data word
// BEHAVIOUR
//  - Reset: o_core_en=1, o_mem_req=0, o_mem_wr=0, o_mem_be=0, o_mem_addr=0, o_mem_wdata=0,
//    o_rom_data=0, o_ram_rdata=0, state IDLE, pending flags cleared.
//  - Capture: in IDLE with o_core_en=1, any of i_rom_en/i_ram_en set -> both requests latched
//    (addr/size/wr/wdata), o_core_en=0 from next cycle. No request -> stay IDLE, core_en stays 1.
//  - FSM: IDLE -> ISSUE_A -> WAIT_A -> [ISSUE_B -> WAIT_B] -> DONE -> IDLE. A/B = ram/rom order per RAM_PRIO;
//    single request skips B. DONE drives o_core_en=1 for exactly one cycle with outputs valid, then IDLE
//    (which may capture again the same cycle the core re-issues).
//  - ISSUE: o_mem_req=1, addr/be/wdata/wr stable until cycle with i_mem_gnt=1. Store completes on gnt
//    (no WAIT, goes to next ISSUE or DONE); load moves to WAIT.
//  - WAIT: stays until i_mem_rvalid=1; rdata registered into o_rom_data or o_ram_rdata that edge.
//  - One transaction outstanding at most; rvalid outside WAIT ignored; gnt outside ISSUE ignored.
//  - Min latency, single load with gnt in first ISSUE cycle, rvalid next: core_en low 3 cycles.
//  - Lanes: B -> be=1<<addr[1:0], wdata={4{wdata[7:0]}}, rdata=zext(lane addr[1:0]);
//    H -> addr[0] ignored, be=addr[1]?1100:0011, wdata={2{wdata[15:0]}}, rdata=zext(half addr[1]);
//    W -> addr[1:0] ignored, be=1111. Fetch always word, be=1111.
//  - Reset mid-operation: abandon transaction immediately, reset values; memory side is reset together.
// STRUCTURE
//  - FSM state encodings as localparams in this file; MEM_B/MEM_H size codes from def.v (no new copies).
//  - One sub-module: armv4_mem_lane (combinational) -> be/wdata from (size,addr,wdata), rdata extraction.
// TESTING
//  1 Fetch 0x100, gnt at once, rvalid+1 rdata 0xE3A00001 -> o_rom_data=0xE3A00001, core_en low 3 cycles.
//  2 Fetch 0x0 + word load 0x2000 same cycle, RAM_PRIO=1 -> mem_addr 0x2000 then 0x0; both data at DONE.
//  3 Byte store 0x2003 wdata 0x000000AB -> mem_addr 0x2000, be=1000, wdata 0xABABABAB, done on gnt.
//  4 Half load 0x2002, rdata 0x1234ABCD -> o_ram_rdata=0x00001234; byte load 0x2001 -> 0x000000AB.
//  5 gnt withheld 5 cycles -> req/addr/be/wdata stable, core_en=0 throughout, then normal completion.
//  6 rst asserted in WAIT, stray rvalid after release -> ignored, core_en=1, all data outputs 0.

Source files
------------

// File: rtl/armv4_mem_arbiter_pkg.sv
// Shared constants for the armv4 memory arbiter: core access-size codes and lane masks.
package armv4_mem_arbiter_pkg;

   // Core ram_size encodings; any other value is treated as a word access.
   localparam logic [1:0] MEM_B  = 2'b00;
   localparam logic [1:0] MEM_H  = 2'b01;
   localparam logic [1:0] MEM_W  = 2'b10;

   localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/armv4_mem_lane.sv
// Byte-lane steering for B/H/W: store byte enables and replicated data, load extraction.
module armv4_mem_lane
   import armv4_mem_arbiter_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] mem_rdata,
   output logic [3:0]  be,
   output logic [31:0] mem_wdata,
   output logic [31:0] rdata
);

   always_comb begin
      be        = BE_ALL;
      mem_wdata = wdata;
      rdata     = mem_rdata;
      case (size)
         MEM_B: begin
            be        = 4'b0001 << addr_lo;
            mem_wdata = {4{wdata[7:0]}};
            rdata     = {24'h0, mem_rdata[{addr_lo, 3'b000} +: 8]};
         end
         MEM_H: begin
            be        = addr_lo[1] ? 4'b1100 : 4'b0011;
            mem_wdata = {2{wdata[15:0]}};
            rdata     = {16'h0, (addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0])};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/armv4_mem_arbiter.sv
// Merges the armv4core fetch and data buses onto one req/gnt/rvalid memory port,
// stalling the core through en while the captured accesses are serviced.
module armv4_mem_arbiter
   import armv4_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter bit RAM_PRIO = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   output logic              o_core_en,
   input  logic              i_rom_en,
   input  logic [ADDR_W-1:0] i_rom_addr,
   output logic [31:0]       o_rom_data,
   input  logic              i_ram_en,
   input  logic              i_ram_wr,
   input  logic [1:0]        i_ram_size,
   input  logic [ADDR_W-1:0] i_ram_addr,
   input  logic [31:0]       i_ram_wdata,
   output logic [31:0]       o_ram_rdata,
   output logic              o_mem_req,
   output logic              o_mem_wr,
   output logic [3:0]        o_mem_be,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [31:0]       o_mem_wdata,
   input  logic              i_mem_gnt,
   input  logic              i_mem_rvalid,
   input  logic [31:0]       i_mem_rdata
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE_A = 3'd1,
      WAIT_A  = 3'd2,
      ISSUE_B = 3'd3,
      WAIT_B  = 3'd4,
      DONE    = 3'd5
   } state_t;

   typedef struct packed {
      logic              wr;
      logic [1:0]        size;
      logic [ADDR_W-1:0] addr;
      logic [3:0]        be;
      logic [31:0]       wdata;
   } ram_req_t;

   state_t            state;
   ram_req_t          ram_q;
   logic [ADDR_W-1:0] rom_addr_q;
   logic              cur_ram;
   logic              has_b;

   logic [1:0]        lane_size;
   logic [1:0]        lane_lo;
   logic [3:0]        lane_be;
   logic [31:0]       lane_wdata;
   logic [31:0]       lane_rdata;

   logic              cap_ram_first;
   logic              more;
   logic              b_ram;
   logic [ADDR_W-1:0] b_addr;
   logic [3:0]        b_be;
   logic [31:0]       b_wdata;
   logic              b_wr;
   logic              unused_rom_lo;

   // Lane logic sees the live core request while capturing, the latched one afterwards.
   assign lane_size = (state == IDLE) ? i_ram_size      : ram_q.size;
   assign lane_lo   = (state == IDLE) ? i_ram_addr[1:0] : ram_q.addr[1:0];

   armv4_mem_lane u_lane (
      .size      (lane_size),
      .addr_lo   (lane_lo),
      .wdata     (i_ram_wdata),
      .mem_rdata (i_mem_rdata),
      .be        (lane_be),
      .mem_wdata (lane_wdata),
      .rdata     (lane_rdata)
   );

   assign cap_ram_first = i_ram_en && (RAM_PRIO || !i_rom_en);
   assign more          = ((state == ISSUE_A) || (state == WAIT_A)) && has_b;
   assign b_ram         = ~cur_ram;
   assign b_addr        = b_ram ? {ram_q.addr[ADDR_W-1:2], 2'b00} : {rom_addr_q[ADDR_W-1:2], 2'b00};
   assign b_be          = b_ram ? ram_q.be    : BE_ALL;
   assign b_wdata       = b_ram ? ram_q.wdata : 32'h0;
   assign b_wr          = b_ram & ram_q.wr;
   assign unused_rom_lo = ^rom_addr_q[1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         ram_q       <= '0;
         rom_addr_q  <= '0;
         cur_ram     <= 1'b0;
         has_b       <= 1'b0;
         o_core_en   <= 1'b1;
         o_mem_req   <= 1'b0;
         o_mem_wr    <= 1'b0;
         o_mem_be    <= 4'h0;
         o_mem_addr  <= '0;
         o_mem_wdata <= 32'h0;
         o_rom_data  <= 32'h0;
         o_ram_rdata <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (o_core_en && (i_rom_en || i_ram_en)) begin
                  ram_q       <= '{wr: i_ram_wr, size: i_ram_size, addr: i_ram_addr,
                                   be: lane_be, wdata: lane_wdata};
                  rom_addr_q  <= i_rom_addr;
                  cur_ram     <= cap_ram_first;
                  has_b       <= i_rom_en && i_ram_en;
                  o_core_en   <= 1'b0;
                  o_mem_req   <= 1'b1;
                  o_mem_wr    <= cap_ram_first & i_ram_wr;
                  o_mem_be    <= cap_ram_first ? lane_be : BE_ALL;
                  o_mem_wdata <= cap_ram_first ? lane_wdata : 32'h0;
                  o_mem_addr  <= cap_ram_first ? {i_ram_addr[ADDR_W-1:2], 2'b00}
                                               : {i_rom_addr[ADDR_W-1:2], 2'b00};
                  state       <= ISSUE_A;
               end
            end
            ISSUE_A, ISSUE_B: begin
               if (i_mem_gnt) begin
                  if (!o_mem_wr) begin
                     o_mem_req <= 1'b0;
                     state     <= (state == ISSUE_A) ? WAIT_A : WAIT_B;
                  end else if (more) begin
                     cur_ram     <= b_ram;
                     o_mem_addr  <= b_addr;
                     o_mem_be    <= b_be;
                     o_mem_wdata <= b_wdata;
                     o_mem_wr    <= b_wr;
                     state       <= ISSUE_B;
                  end else begin
                     o_mem_req <= 1'b0;
                     state     <= DONE;
                  end
               end
            end
            WAIT_A, WAIT_B: begin
               if (i_mem_rvalid) begin
                  if (cur_ram) o_ram_rdata <= lane_rdata;
                  else         o_rom_data  <= i_mem_rdata;
                  if (more) begin
                     cur_ram     <= b_ram;
                     o_mem_req   <= 1'b1;
                     o_mem_addr  <= b_addr;
                     o_mem_be    <= b_be;
                     o_mem_wdata <= b_wdata;
                     o_mem_wr    <= b_wr;
                     state       <= ISSUE_B;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               o_core_en <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_armv4_mem_arbiter.sv
// Directed bench for armv4_mem_arbiter: fetch, merged fetch+load, lane steering, gnt stall, mid-op reset.
module tb_armv4_mem_arbiter;
   import armv4_mem_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        o_core_en;
   logic        i_rom_en;
   logic [31:0] i_rom_addr;
   logic [31:0] o_rom_data;
   logic        i_ram_en;
   logic        i_ram_wr;
   logic [1:0]  i_ram_size;
   logic [31:0] i_ram_addr;
   logic [31:0] i_ram_wdata;
   logic [31:0] o_ram_rdata;
   logic        o_mem_req;
   logic        o_mem_wr;
   logic [3:0]  o_mem_be;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic        i_mem_gnt;
   logic        i_mem_rvalid;
   logic [31:0] i_mem_rdata;

   int checks = 0;
   int errors = 0;

   logic [31:0] log_addr  [4];
   logic [3:0]  log_be    [4];
   logic [31:0] log_wdata [4];
   logic        log_wr    [4];
   int          n_log;

   always #5 clk = ~clk;

   armv4_mem_arbiter #(.ADDR_W(32), .RAM_PRIO(1'b1)) dut (
      .clk          (clk),
      .rst          (rst),
      .o_core_en    (o_core_en),
      .i_rom_en     (i_rom_en),
      .i_rom_addr   (i_rom_addr),
      .o_rom_data   (o_rom_data),
      .i_ram_en     (i_ram_en),
      .i_ram_wr     (i_ram_wr),
      .i_ram_size   (i_ram_size),
      .i_ram_addr   (i_ram_addr),
      .i_ram_wdata  (i_ram_wdata),
      .o_ram_rdata  (o_ram_rdata),
      .o_mem_req    (o_mem_req),
      .o_mem_wr     (o_mem_wr),
      .o_mem_be     (o_mem_be),
      .o_mem_addr   (o_mem_addr),
      .o_mem_wdata  (o_mem_wdata),
      .i_mem_gnt    (i_mem_gnt),
      .i_mem_rvalid (i_mem_rvalid),
      .i_mem_rdata  (i_mem_rdata)
   );

   // Present one core request for a single cycle, then drop it (core is stalled afterwards).
   task automatic issue(input logic rom_en, input logic [31:0] rom_addr,
                        input logic ram_en, input logic wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata);
      i_rom_en    = rom_en;
      i_rom_addr  = rom_addr;
      i_ram_en    = ram_en;
      i_ram_wr    = wr;
      i_ram_size  = size;
      i_ram_addr  = addr;
      i_ram_wdata = wdata;
      @(posedge clk); #1;
      i_rom_en = 1'b0;
      i_ram_en = 1'b0;
   endtask

   // Memory responder: grants after gnt_wait cycles, returns rd0 then rd1 one cycle after each read grant.
   task automatic serve(input int gnt_wait, input logic [31:0] rd0, input logic [31:0] rd1,
                        output int low);
      int  waited = 0;
      int  ridx = 0;
      bit  pend = 0;
      bit  done = 0;
      low   = 0;
      n_log = 0;
      for (int c = 0; c < 60 && !done; c++) begin
         if (o_core_en) begin
            done = 1;
         end else begin
            low++;
            i_mem_rvalid = pend;
            i_mem_rdata  = pend ? ((ridx == 0) ? rd0 : rd1) : 32'hDEAD_BEEF;
            if (pend) ridx++;
            pend      = 0;
            i_mem_gnt = 1'b0;
            if (o_mem_req) begin
               if (waited >= gnt_wait) begin
                  i_mem_gnt = 1'b1;
                  if (n_log < 4) begin
                     log_addr[n_log]  = o_mem_addr;
                     log_be[n_log]    = o_mem_be;
                     log_wdata[n_log] = o_mem_wdata;
                     log_wr[n_log]    = o_mem_wr;
                  end
                  n_log++;
                  pend   = !o_mem_wr;
                  waited = 0;
               end else begin
                  waited++;
               end
            end
            @(posedge clk); #1;
         end
      end
      i_mem_gnt    = 1'b0;
      i_mem_rvalid = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL serve_timeout: core_en still %0b after 60 cycles, required 1", o_core_en);
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({o_core_en, o_mem_req, o_mem_wr, o_mem_be} !== 7'b1000000) begin
         errors++;
         $display("FAIL reset_ctrl: core_en/req/wr/be=%b required 1000000",
                  {o_core_en, o_mem_req, o_mem_wr, o_mem_be});
      end
      checks++;
      if ({o_mem_addr, o_mem_wdata, o_rom_data, o_ram_rdata} !== 128'h0) begin
         errors++;
         $display("FAIL reset_data: addr=%h wdata=%h rom=%h ram=%h required all 0",
                  o_mem_addr, o_mem_wdata, o_rom_data, o_ram_rdata);
      end
      rst = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         checks++;
         if (o_core_en !== 1'b1 || o_mem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: core_en=%b req=%b required 1 0", o_core_en, o_mem_req);
         end
      end
   endtask

   task automatic test_fetch();
      int low;
      issue(1'b1, 32'h100, 1'b0, 1'b0, MEM_W, 32'h0, 32'h0);
      checks++;
      if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h100 || o_mem_be !== 4'hF || o_mem_wr !== 1'b0) begin
         errors++;
         $display("FAIL fetch_issue: req=%b addr=%h be=%b wr=%b required 1 00000100 1111 0",
                  o_mem_req, o_mem_addr, o_mem_be, o_mem_wr);
      end
      serve(0, 32'hE3A0_0001, 32'h0, low);
      checks++;
      if (o_rom_data !== 32'hE3A0_0001) begin
         errors++;
         $display("FAIL fetch_data: got %h required e3a00001", o_rom_data);
      end
      checks++;
      if (low != 3) begin
         errors++;
         $display("FAIL fetch_latency: core_en low %0d cycles required 3", low);
      end
   endtask

   task automatic test_dual();
      int low;
      issue(1'b1, 32'h0, 1'b1, 1'b0, MEM_W, 32'h2000, 32'h0);
      serve(0, 32'h1111_2222, 32'hE1A0_0000, low);
      checks++;
      if (n_log != 2 || log_addr[0] !== 32'h2000 || log_addr[1] !== 32'h0) begin
         errors++;
         $display("FAIL dual_order: n=%0d addr0=%h addr1=%h required 2 00002000 00000000",
                  n_log, log_addr[0], log_addr[1]);
      end
      checks++;
      if (o_ram_rdata !== 32'h1111_2222 || o_rom_data !== 32'hE1A0_0000) begin
         errors++;
         $display("FAIL dual_data: ram=%h rom=%h required 11112222 e1a00000", o_ram_rdata, o_rom_data);
      end
      checks++;
      if (low != 5) begin
         errors++;
         $display("FAIL dual_latency: core_en low %0d cycles required 5", low);
      end
   endtask

   task automatic test_byte_store();
      int low;
      issue(1'b0, 32'h0, 1'b1, 1'b1, MEM_B, 32'h2003, 32'h0000_00AB);
      serve(0, 32'h0, 32'h0, low);
      checks++;
      if (log_addr[0] !== 32'h2000 || log_be[0] !== 4'b1000 || log_wdata[0] !== 32'hABAB_ABAB
          || log_wr[0] !== 1'b1) begin
         errors++;
         $display("FAIL bstore_bus: addr=%h be=%b wdata=%h wr=%b required 00002000 1000 abababab 1",
                  log_addr[0], log_be[0], log_wdata[0], log_wr[0]);
      end
      checks++;
      if (low != 2) begin
         errors++;
         $display("FAIL bstore_latency: core_en low %0d cycles required 2", low);
      end
   endtask

   task automatic test_sub_loads();
      int low;
      issue(1'b0, 32'h0, 1'b1, 1'b0, MEM_H, 32'h2002, 32'h0);
      serve(0, 32'h1234_ABCD, 32'h0, low);
      checks++;
      if (o_ram_rdata !== 32'h0000_1234 || log_be[0] !== 4'b1100 || log_addr[0] !== 32'h2000) begin
         errors++;
         $display("FAIL hload: rdata=%h be=%b addr=%h required 00001234 1100 00002000",
                  o_ram_rdata, log_be[0], log_addr[0]);
      end
      issue(1'b0, 32'h0, 1'b1, 1'b0, MEM_B, 32'h2001, 32'h0);
      serve(0, 32'h1234_ABCD, 32'h0, low);
      checks++;
      if (o_ram_rdata !== 32'h0000_00AB || log_be[0] !== 4'b0010) begin
         errors++;
         $display("FAIL bload: rdata=%h be=%b required 000000ab 0010", o_ram_rdata, log_be[0]);
      end
   endtask

   task automatic test_gnt_stall();
      int low;
      issue(1'b0, 32'h0, 1'b1, 1'b1, MEM_H, 32'h3002, 32'h0000_BEEF);
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h3000 || o_mem_be !== 4'b1100
             || o_mem_wdata !== 32'hBEEF_BEEF || o_core_en !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold c%0d: req=%b addr=%h be=%b wdata=%h en=%b required 1 00003000 1100 beefbeef 0",
                     c, o_mem_req, o_mem_addr, o_mem_be, o_mem_wdata, o_core_en);
         end
         @(posedge clk); #1;
      end
      serve(0, 32'h0, 32'h0, low);
      checks++;
      if (low != 2 || n_log != 1 || log_wdata[0] !== 32'hBEEF_BEEF) begin
         errors++;
         $display("FAIL stall_done: low=%0d n=%0d wdata=%h required 2 1 beefbeef", low, n_log, log_wdata[0]);
      end
   endtask

   task automatic test_reset_mid();
      issue(1'b0, 32'h0, 1'b1, 1'b0, MEM_W, 32'h4000, 32'h0);
      i_mem_gnt = 1'b1;
      @(posedge clk); #1;
      i_mem_gnt = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if (o_core_en !== 1'b1 || o_mem_req !== 1'b0 || o_rom_data !== 32'h0 || o_ram_rdata !== 32'h0) begin
         errors++;
         $display("FAIL rst_async: en=%b req=%b rom=%h ram=%h required 1 0 0 0",
                  o_core_en, o_mem_req, o_rom_data, o_ram_rdata);
      end
      @(posedge clk); #1;
      rst          = 1'b0;
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'h5555_5555;
      @(posedge clk); #1;
      i_mem_rvalid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (o_core_en !== 1'b1 || o_mem_req !== 1'b0 || o_rom_data !== 32'h0 || o_ram_rdata !== 32'h0
          || o_mem_addr !== 32'h0 || o_mem_wdata !== 32'h0) begin
         errors++;
         $display("FAIL rst_stray_rvalid: en=%b req=%b rom=%h ram=%h addr=%h wdata=%h required 1 0 0 0 0 0",
                  o_core_en, o_mem_req, o_rom_data, o_ram_rdata, o_mem_addr, o_mem_wdata);
      end
   endtask

   initial begin
      rst          = 1'b1;
      i_rom_en     = 1'b0;
      i_rom_addr   = 32'h0;
      i_ram_en     = 1'b0;
      i_ram_wr     = 1'b0;
      i_ram_size   = MEM_W;
      i_ram_addr   = 32'h0;
      i_ram_wdata  = 32'h0;
      i_mem_gnt    = 1'b0;
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_fetch();
      test_dual();
      test_byte_store();
      test_sub_loads();
      test_gnt_stall();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
